// File: rtl/cam_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cam_pkg : shared DVP camera types, byte-phase constants and default timing
// Rev 1.0
// ---------------------------------------------------------------------------
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFP    = 3'd5
  } cam_state_e;

  localparam logic BYTE_HI = 1'b0;
  localparam logic BYTE_LO = 1'b1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_H_BLANK  = 288;
  localparam int DEF_VS_CYC   = 3136;
  localparam int DEF_V_BP     = 2000;
  localparam int DEF_V_FP     = 1000;

  // Counter runs 0..N-1, so clog2 of the longest interval is enough.
  function automatic int timing_cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/send_cam_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// send_cam_if : pixel stream in, DVP camera bus out
// Rev 1.0
// ---------------------------------------------------------------------------
interface send_cam_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  cmos_data;
  logic        cmos_href;
  logic        cmos_vsyn;

  modport master (
    input  pix_data, pix_valid,
    output pix_ready, cmos_data, cmos_href, cmos_vsyn
  );

  modport slave (
    output pix_data, pix_valid,
    input  pix_ready, cmos_data, cmos_href, cmos_vsyn
  );
endinterface
`default_nettype wire

// File: rtl/dvp_timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dvp_timing_gen : frame/line FSM with counters and pixel-request decode
// Rev 1.0
// ---------------------------------------------------------------------------
module dvp_timing_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int VS_CYC   = DEF_VS_CYC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_FP     = DEF_V_FP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  output cam_state_e state_o,
  output logic       phase_o,
  output logic       pix_ready_o,
  output logic       frame_end_o
);

  localparam int CNT_W  = timing_cnt_w(VS_CYC, V_BP, H_BLANK, V_FP);
  localparam int PIX_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [CNT_W-1:0]  VS_LAST   = CNT_W'(VS_CYC - 1);
  localparam logic [CNT_W-1:0]  VBP_LAST  = CNT_W'(V_BP - 1);
  localparam logic [CNT_W-1:0]  HB_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0]  VFP_LAST  = CNT_W'(V_FP - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);

  cam_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              phase_q;
  logic [PIX_W-1:0]  pix_q;
  logic [LINE_W-1:0] line_q;

  logic line_end;
  assign line_end = (phase_q == BYTE_LO) && (pix_q == PIX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      phase_q <= BYTE_HI;
      pix_q   <= '0;
      line_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (enable_i) state_q <= ST_VSYNC;
        end
        ST_VSYNC: begin
          if (cnt_q == VS_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_VBP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_VBP: begin
          if (cnt_q == VBP_LAST) begin
            cnt_q   <= '0;
            phase_q <= BYTE_HI;
            pix_q   <= '0;
            line_q  <= '0;
            state_q <= ST_ACTIVE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          phase_q <= ~phase_q;
          if (line_end) begin
            pix_q   <= '0;
            phase_q <= BYTE_HI;
            if (line_q == LINE_LAST) begin
              state_q <= ST_VFP;
            end else begin
              line_q  <= line_q + LINE_W'(1);
              state_q <= ST_HBLANK;
            end
          end else if (phase_q == BYTE_LO) begin
            pix_q <= pix_q + PIX_W'(1);
          end
        end
        ST_HBLANK: begin
          if (cnt_q == HB_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_ACTIVE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_VFP: begin
          if (cnt_q == VFP_LAST) begin
            cnt_q   <= '0;
            // enable is only looked at here and in IDLE, so frames never truncate.
            state_q <= enable_i ? ST_VSYNC : ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request a pixel in the cycle before every high byte.
  assign pix_ready_o = ((state_q == ST_VBP)    && (cnt_q == VBP_LAST)) ||
                       ((state_q == ST_HBLANK) && (cnt_q == HB_LAST))  ||
                       ((state_q == ST_ACTIVE) && (phase_q == BYTE_LO) && !line_end);

  assign frame_end_o = (state_q == ST_VFP) && (cnt_q == VFP_LAST);
  assign state_o     = state_q;
  assign phase_o     = phase_q;

endmodule
`default_nettype wire

// File: rtl/send_cam.sv
`default_nettype none
// ---------------------------------------------------------------------------
// send_cam : serialises 16-bit pixels MSB-first onto an 8-bit DVP camera bus
// Rev 1.0
// ---------------------------------------------------------------------------
module send_cam
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int VS_CYC   = DEF_VS_CYC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_FP     = DEF_V_FP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  send_cam_if.master        bus,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              underrun,
  output logic              busy
);

  cam_state_e state;
  logic       phase;
  logic       pix_ready;
  logic       frame_end;

  dvp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .VS_CYC   (VS_CYC),
    .V_BP     (V_BP),
    .V_FP     (V_FP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .state_o     (state),
    .phase_o     (phase),
    .pix_ready_o (pix_ready),
    .frame_end_o (frame_end)
  );

  logic [15:0] pix_q, pix_d;
  logic        underrun_q, underrun_d;
  logic        frame_done_q;
  logic [15:0] frame_cnt_q;

  // A missing pixel is replaced by black; timing never waits for the source.
  always_comb begin
    pix_d      = pix_q;
    underrun_d = underrun_q;
    if (pix_ready) begin
      pix_d      = bus.pix_valid ? bus.pix_data : 16'h0000;
      underrun_d = underrun_q | ~bus.pix_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q        <= '0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      pix_q        <= pix_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_end;
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  logic href;
  assign href = (state == ST_ACTIVE);

  assign bus.pix_ready = pix_ready;
  assign bus.cmos_href = href;
  assign bus.cmos_vsyn = (state == ST_VSYNC);
  assign bus.cmos_data = !href             ? 8'h00 :
                         (phase == BYTE_HI) ? pix_q[15:8] : pix_q[7:0];

  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign underrun   = underrun_q;
  assign busy       = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_send_cam.sv
`timescale 1ns/1ps
// Self-checking bench for send_cam with small timing parameters and a
// stream-level reference model (expected bytes, frame length from formula).
module tb_send_cam;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HB = 3;
  localparam int VS = 5;
  localparam int VB = 2;
  localparam int VF = 2;
  localparam int FRAME_LEN = VS + VB + V*2*H + (V-1)*HB + VF;
  localparam int PIX_PER_FRAME = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        underrun;
  logic        busy;

  send_cam_if bus();

  send_cam #(
    .H_ACTIVE (H), .V_ACTIVE (V), .H_BLANK (HB),
    .VS_CYC   (VS), .V_BP    (VB), .V_FP   (VF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bus        (bus),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] sent_q[$];
  logic [7:0]  bytes_q[$];
  int          vs_rise_q[$];
  int          done_cyc_q[$];
  int          cyc = 0;
  int          offered = 0;
  int          drop_idx = -1;
  bit          use_fixed = 1'b0;
  int          done_cnt = 0;
  int          idle_bad = 0;
  int          fc_bad = 0;
  logic        prev_vs = 1'b0;
  logic [15:0] prev_fc = 16'h0;

  // Pixel source and bus monitor, both at the falling edge.
  initial begin
    logic [15:0] pix;
    logic [15:0] fc_next;
    bus.pix_data  = '0;
    bus.pix_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.cmos_href) bytes_q.push_back(bus.cmos_data);
      else if (bus.cmos_data !== 8'h00) idle_bad++;
      if (bus.cmos_vsyn === 1'b1 && prev_vs === 1'b0) vs_rise_q.push_back(cyc);
      prev_vs = bus.cmos_vsyn;
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
        fc_next = prev_fc + 16'd1;
        if (frame_cnt !== fc_next) fc_bad++;
      end
      prev_fc = frame_cnt;
      if (bus.pix_ready === 1'b1) begin
        pix = use_fixed ? 16'h1234 + 16'(offered) * 16'h4444 : 16'($urandom);
        bus.pix_data  = pix;
        bus.pix_valid = (offered != drop_idx);
        sent_q.push_back((offered != drop_idx) ? pix : 16'h0000);
        offered++;
      end else begin
        bus.pix_data  = 16'($urandom);
        bus.pix_valid = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_model();
    sent_q.delete();
    bytes_q.delete();
    vs_rise_q.delete();
    done_cyc_q.delete();
    offered  = 0;
    done_cnt = 0;
    idle_bad = 0;
    fc_bad   = 0;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    clear_model();
    rst_n = 1'b1;
    tick();
  endtask

  // Number of observed bytes disagreeing with the accepted-word model.
  function automatic int stream_errors();
    int n = 0;
    if (bytes_q.size() != 2 * sent_q.size()) return 1 + bytes_q.size();
    foreach (sent_q[i]) begin
      if (bytes_q[2*i]   !== sent_q[i][15:8]) n++;
      if (bytes_q[2*i+1] !== sent_q[i][7:0])  n++;
    end
    return n;
  endfunction

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt < target) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: frame_done count %0d, required %0d", tag, done_cnt, target);
    end
  endtask

  task automatic wait_href(input int budget, input string tag);
    int n = 0;
    while (bus.cmos_href !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (bus.cmos_href !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL %s timeout waiting for href", tag);
    end
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    tick();
    outs = {bus.cmos_data, bus.cmos_href, bus.cmos_vsyn, bus.pix_ready,
            frame_done, underrun, busy, frame_cnt, 2'b00};
    checks++;
    if (outs !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", outs);
    end
    apply_reset();
    checks++;
    if (busy !== 1'b0 || bus.cmos_vsyn !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b vsyn=%b required 0,0", busy, bus.cmos_vsyn);
    end
  endtask

  task automatic test_fixed_frames();
    use_fixed = 1'b1;
    enable = 1'b1;
    tick();
    checks++;
    if (bus.cmos_vsyn !== 1'b1) begin
      errors++;
      $display("FAIL first_vsyn got %b required 1", bus.cmos_vsyn);
    end
    wait_done(1, 3 * FRAME_LEN, "fixed_f1");
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL fixed_cnt1 got %0d required 1", frame_cnt);
    end
    enable = 1'b0;
    wait_done(2, 3 * FRAME_LEN, "fixed_f2");
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || bus.cmos_vsyn !== 1'b0 || done_cnt != 2) begin
      errors++;
      $display("FAIL fixed_idle busy=%b vsyn=%b done=%0d required 0,0,2", busy, bus.cmos_vsyn, done_cnt);
    end
    checks++;
    if (vs_rise_q.size() != 2 || vs_rise_q[1] - vs_rise_q[0] != FRAME_LEN) begin
      errors++;
      $display("FAIL fixed_period rises=%0d got %0d required %0d", vs_rise_q.size(),
               (vs_rise_q.size() > 1) ? vs_rise_q[1] - vs_rise_q[0] : -1, FRAME_LEN);
    end
    checks++;
    if (done_cyc_q.size() < 1 || vs_rise_q.size() < 1 || done_cyc_q[0] - vs_rise_q[0] != FRAME_LEN) begin
      errors++;
      $display("FAIL fixed_done_pos got %0d required %0d",
               (done_cyc_q.size() > 0 && vs_rise_q.size() > 0) ? done_cyc_q[0] - vs_rise_q[0] : -1, FRAME_LEN);
    end
    checks++;
    if (bytes_q.size() < 4 || {bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3]} !== 32'h12345678) begin
      errors++;
      $display("FAIL fixed_first_bytes got %0d bytes, required 12 34 56 78 leading", bytes_q.size());
    end
    checks++;
    if (bytes_q.size() != 4 * PIX_PER_FRAME || stream_errors() != 0) begin
      errors++;
      $display("FAIL fixed_stream bytes=%0d bad=%0d required %0d,0", bytes_q.size(), stream_errors(), 4 * PIX_PER_FRAME);
    end
    checks++;
    if (fc_bad != 0 || idle_bad != 0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL fixed_misc fc_bad=%0d idle_bad=%0d underrun=%b required 0,0,0", fc_bad, idle_bad, underrun);
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_random_frames();
    clear_model();
    enable = 1'b1;
    wait_done(2, 4 * FRAME_LEN, "rand_f2");
    enable = 1'b0;
    wait_done(3, 3 * FRAME_LEN, "rand_f3");
    repeat (3) tick();
    checks++;
    if (frame_cnt !== 16'd5) begin
      errors++;
      $display("FAIL rand_cnt got %0d required 5", frame_cnt);
    end
    checks++;
    if (vs_rise_q.size() != 3 || vs_rise_q[1] - vs_rise_q[0] != FRAME_LEN || vs_rise_q[2] - vs_rise_q[1] != FRAME_LEN) begin
      errors++;
      $display("FAIL rand_period rises=%0d required 3 spaced %0d", vs_rise_q.size(), FRAME_LEN);
    end
    checks++;
    if (bytes_q.size() != 6 * PIX_PER_FRAME || stream_errors() != 0) begin
      errors++;
      $display("FAIL rand_stream bytes=%0d bad=%0d required %0d,0", bytes_q.size(), stream_errors(), 6 * PIX_PER_FRAME);
    end
    checks++;
    if (fc_bad != 0 || idle_bad != 0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL rand_misc fc_bad=%0d idle_bad=%0d underrun=%b required 0,0,0", fc_bad, idle_bad, underrun);
    end
  endtask

  task automatic test_underrun();
    apply_reset();
    drop_idx = 3;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_done(1, 3 * FRAME_LEN, "underrun_f");
    repeat (5) tick();
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky got %b required 1", underrun);
    end
    checks++;
    if (bytes_q.size() < 8 || bytes_q[6] !== 8'h00 || bytes_q[7] !== 8'h00) begin
      errors++;
      $display("FAIL underrun_bytes got %0d bytes, pixel 3 required 00 00", bytes_q.size());
    end
    checks++;
    if (stream_errors() != 0 || bytes_q.size() != 2 * PIX_PER_FRAME) begin
      errors++;
      $display("FAIL underrun_stream bytes=%0d bad=%0d required %0d,0", bytes_q.size(), stream_errors(), 2 * PIX_PER_FRAME);
    end
    checks++;
    if (done_cyc_q.size() != 1 || vs_rise_q.size() != 1 || done_cyc_q[0] - vs_rise_q[0] != FRAME_LEN) begin
      errors++;
      $display("FAIL underrun_timing done=%0d rises=%0d required 1 frame of %0d", done_cyc_q.size(), vs_rise_q.size(), FRAME_LEN);
    end
    drop_idx = -1;
  endtask

  task automatic test_enable_drop();
    apply_reset();
    enable = 1'b1;
    wait_href(4 * FRAME_LEN, "drop_href");
    enable = 1'b0;
    wait_done(1, 3 * FRAME_LEN, "drop_f");
    repeat (FRAME_LEN + 5) tick();
    checks++;
    if (done_cnt != 1 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_count done=%0d cnt=%0d required 1,1", done_cnt, frame_cnt);
    end
    checks++;
    if (busy !== 1'b0 || bus.cmos_vsyn !== 1'b0 || vs_rise_q.size() != 1) begin
      errors++;
      $display("FAIL drop_idle busy=%b vsyn=%b rises=%0d required 0,0,1", busy, bus.cmos_vsyn, vs_rise_q.size());
    end
    checks++;
    if (stream_errors() != 0 || bytes_q.size() != 2 * PIX_PER_FRAME) begin
      errors++;
      $display("FAIL drop_stream bytes=%0d bad=%0d required %0d,0", bytes_q.size(), stream_errors(), 2 * PIX_PER_FRAME);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] outs;
    enable = 1'b1;
    wait_href(4 * FRAME_LEN, "arst_href");
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.cmos_data, bus.cmos_href, bus.cmos_vsyn, bus.pix_ready,
            frame_done, underrun, busy, frame_cnt, 2'b00};
    checks++;
    if (outs !== 32'h0) begin
      errors++;
      $display("FAIL arst_outputs got %h required 0", outs);
    end
    tick();
    clear_model();
    rst_n = 1'b1;
    checks++;
    if (bus.cmos_vsyn !== 1'b0) begin
      errors++;
      $display("FAIL arst_release_vsyn got %b required 0", bus.cmos_vsyn);
    end
    tick();
    checks++;
    if (bus.cmos_vsyn !== 1'b1) begin
      errors++;
      $display("FAIL arst_first_vsyn got %b required 1", bus.cmos_vsyn);
    end
    enable = 1'b0;
    wait_done(1, 3 * FRAME_LEN, "arst_f");
    repeat (3) tick();
    checks++;
    if (done_cyc_q.size() != 1 || vs_rise_q.size() != 1 || done_cyc_q[0] - vs_rise_q[0] != FRAME_LEN
        || stream_errors() != 0) begin
      errors++;
      $display("FAIL arst_frame done=%0d rises=%0d bad=%0d required one clean frame", done_cyc_q.size(),
               vs_rise_q.size(), stream_errors());
    end
  endtask

  task automatic test_wrap();
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload got %h required ffff", frame_cnt);
    end
    clear_model();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_done(1, 3 * FRAME_LEN, "wrap_f");
    tick();
    checks++;
    if (frame_cnt !== 16'h0000 || fc_bad != 0) begin
      errors++;
      $display("FAIL wrap_cnt got %h fc_bad=%0d required 0000,0", frame_cnt, fc_bad);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_frames();
    test_random_frames();
    test_underrun();
    test_enable_drop();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/send_cam.md
# send_cam

DVP-style camera transmitter. It accepts 16-bit pixels on a valid/ready stream and serialises them MSB-byte-first onto an 8-bit camera bus with `cmos_href`/`cmos_vsyn` framing. The framing matches what `recv_cam` consumes: `cmos_vsyn` high outside frames, `cmos_href` high during active bytes. It drives the camera-input path in loopback and simulation, and feeds any downstream block that expects a sensor-format stream.

## Interface
**Parameters**
- `H_ACTIVE`, 640: pixels per line; each line is `2*H_ACTIVE` byte cycles.
- `V_ACTIVE`, 480: active lines per frame.
- `H_BLANK`, 288: `href`-low cycles between consecutive lines.
- `VS_CYC`, 3136: `cmos_vsyn` high cycles per frame.
- `V_BP`, 2000: cycles from `vsyn` fall to the first `href` rise.
- `V_FP`, 1000: cycles from the last `href` fall to end of frame.

**Ports**
- `clk`, input, 1: sole clock; all outputs change on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `enable`, input, 1: level; frames start while high.
- `pix_data`, input, 16: pixel; [15:8] is sent first.
- `pix_valid`, input, 1: `pix_data` valid.
- `pix_ready`, output, 1: pixel consumed this cycle if `pix_valid` is high.
- `cmos_data`, output, 8: bus byte.
- `cmos_href`, output, 1: line-active qualifier.
- `cmos_vsyn`, output, 1: frame sync, active high.
- `frame_done`, output, 1: one-cycle pulse at end of frame.
- `frame_cnt`, output, 16: completed frames; wraps 0xFFFF→0.
- `underrun`, output, 1: sticky; set when a pixel was needed and `pix_valid` was low.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP.
- A cycle counter (width ≥ clog2 of the largest timing parameter) times every state except IDLE. Separate counters: byte phase (1 bit), pixel index (clog2(H_ACTIVE)), line index (clog2(V_ACTIVE)).
- IDLE → VSYNC when `enable`=1.
- VSYNC: `vsyn`=1 for `VS_CYC` cycles → VBP.
- VBP: `V_BP` cycles → ACTIVE.
- ACTIVE: `href`=1 for `2*H_ACTIVE` cycles. Even byte phase emits the latched pixel [15:8]; odd phase emits [7:0]. End of line → HBLANK if more lines remain, else VFP.
- HBLANK: `H_BLANK` cycles → ACTIVE.
- VFP: `V_FP` cycles. On its last cycle: pulse `frame_done`, increment `frame_cnt`. Then → VSYNC if `enable`=1, else IDLE.
- `enable` is sampled only at the IDLE and end-of-VFP decision points. Dropping it mid-frame never truncates a frame.
- Outside ACTIVE, `cmos_data`=0x00 and `href`=0.
- Underrun: if `pix_ready`=1 and `pix_valid`=0, the pixel is sent as 0x0000 and `underrun` is set. Timing never stalls. `underrun` clears only on reset.

## Timing
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- Asynchronous assertion of `rst_n` mid-frame forces IDLE immediately with `vsyn`/`href` low. There is no partial-frame recovery.
- First `vsyn` high appears 1 cycle after `enable` is sampled high in IDLE.
- `pix_ready` is combinational from state. It is high exactly in the cycle before each even byte:
  - the last cycle of VBP or HBLANK;
  - every odd-byte cycle of ACTIVE except the last byte of the line.
- It is therefore high once per pixel, `H_ACTIVE` times per line.
- Latency: pixel accepted in cycle N → [15:8] on `cmos_data` at N+1, [7:0] at N+2.
- Frame length in clk cycles: `VS_CYC + V_BP + V_ACTIVE*2*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_FP`.
- `frame_done` rises in the same cycle as the `frame_cnt` update.
- With `enable` held high, the next `vsyn` rise follows 1 cycle later.

## Structure
- Shared package `cam_pkg`: FSM state enum, byte-phase constants (`BYTE_HI`, `BYTE_LO`), default timing constants. `recv_cam` test benches reuse these.
- One sub-module, `dvp_timing_gen`:
  - contains the FSM and counters;
  - outputs state, byte phase, and the `pix_ready` decode.
- `send_cam` adds the pixel latch, byte mux, underrun flag and frame counter.

## Test plan
- Small params (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VS_CYC=5, V_BP=2, V_FP=2), pixels 0x1234, 0x5678, …, always valid. `cmos_data` during `href` must read 12,34,56,78,… and each frame must be exactly 5+2+16+3+2=28 cycles.
- Loopback into `recv_cam` (`cfg_done`=1), `enable` held for 32 frames. Frames 31 onward must produce `data_16b`/`data_16b_en` equal to the sent pixels, with en high H_ACTIVE×V_ACTIVE times per frame.
- Deassert `pix_valid` for pixel 3 of line 0. That pixel must be sent as 00,00, `underrun` must go high and stay high, and frame timing must be unchanged.
- Drop `enable` during ACTIVE of frame 0. The frame must complete, `frame_done` must pulse once, `frame_cnt` must become 1, and the FSM must return to IDLE with `vsyn` low.
- Assert `rst_n`=0 mid-line. All outputs must go 0 asynchronously. After release with `enable`=1, the first `vsyn` must appear 1 cycle later.
- Preload `frame_cnt` to 0xFFFF by forcing, then complete one frame. `frame_cnt` must read 0x0000.
